dmem_responder: RTL and testbench

//  - Data-memory responder: the slave end of the core's load/store port (ram_ce/ram_we/ram_sel/ram_addr).
//  - Word-organised RAM with byte-lane writes and a fixed, parameterised access latency.
//  - Completes each access with a one-cycle ram_ready pulse; the core stalls MEM until that pulse.
//  - Sits between u_core_top and soc_top, replacing the zero-latency u_ram.

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: word RAM with byte lanes and a fixed access latency.
// Optional per-byte even parity with error reporting on reads is enabled by defining DMEM_PARITY_EN.
module dmem_responder #(
  parameter int unsigned DEPTH       = 2048,
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce,
  input  logic        ram_we,
  input  logic [31:0] ram_addr,
  input  logic [3:0]  ram_sel,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic        ram_ready,
  output logic        ram_err
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdata;
  logic [IDX_W-1:0]  r_idx;
  logic              r_range_ok;
  logic [3:0]        r_cnt;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic [31:0] ram_mem [0:DEPTH-1];
`ifdef DMEM_PARITY_EN
  logic [3:0]  ram_par [0:DEPTH-1];

  function automatic logic [3:0] byte_par(input logic [31:0] word);
    return {^word[31:24], ^word[23:16], ^word[15:8], ^word[7:0]};
  endfunction
`endif

  // A borrow out of the subtraction means the address lies below ADDR_BASE.
  logic              w_borrow;
  logic [31:0]       w_offset;
  logic [31:0]       w_word;
  logic              w_in_range;
  logic              w_accept;
  logic [IDX_W-1:0]  w_cur_idx;
  logic              w_cur_we;
  logic              w_cur_ok;
  logic [31:0]       w_rd_word;

  assign {w_borrow, w_offset} = {1'b0, ram_addr} - {1'b0, ADDR_BASE};
  assign w_word     = w_offset >> 2;
  assign w_in_range = !w_borrow && (w_word < 32'(DEPTH));
  assign w_accept   = (r_state == S_IDLE) && ram_ce;

  // With zero wait cycles the response is loaded on the accepting edge, so use the live request.
  assign w_cur_idx = w_accept ? w_word[IDX_W-1:0] : r_idx;
  assign w_cur_we  = w_accept ? ram_we : r_we;
  assign w_cur_ok  = w_accept ? w_in_range : r_range_ok;
  assign w_rd_word = ram_mem[w_cur_idx];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ram_ce) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_sel      <= 4'd0;
      r_wdata    <= 32'd0;
      r_idx      <= '0;
      r_range_ok <= 1'b0;
      r_cnt      <= 4'd0;
    end else if (w_accept) begin
      r_we       <= ram_we;
      r_sel      <= ram_sel;
      r_wdata    <= ram_wdata;
      r_idx      <= w_word[IDX_W-1:0];
      r_range_ok <= w_in_range;
      r_cnt      <= WAIT_LOAD;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Response registers load on the edge entering RESP; rdata then holds until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_next == S_RESP) begin
      if (!w_cur_ok) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b1;
      end else begin
`ifdef DMEM_PARITY_EN
        r_err <= !w_cur_we && (byte_par(w_rd_word) != ram_par[w_cur_idx]);
`else
        r_err <= 1'b0;
`endif
        if (!w_cur_we) r_rdata <= w_rd_word;
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive rst and are preloaded externally.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_RESP && r_we && r_range_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) begin
          ram_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
`ifdef DMEM_PARITY_EN
          ram_par[r_idx][b]        <= ^r_wdata[8*b +: 8];
`endif
        end
      end
    end
  end

  assign ram_ready = (r_state == S_RESP);
  assign ram_err   = ram_ready && r_err;
  assign ram_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a word-array model with a scoreboard queue, checked every cycle,
// plus literal expectations; a second zero-wait instance checks the minimum latency.
module tb_dmem_responder;

  localparam int DEPTH = 2048;
  localparam int W     = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic        ram_ready, ram_err;

  logic        z_ce, z_we;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [3:0]  z_sel;
  logic        z_ready, z_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .ADDR_BASE(32'h0), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_sel(ram_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ready(ram_ready), .ram_err(ram_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .ADDR_BASE(32'h0), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ram_ce(z_ce), .ram_we(z_we), .ram_addr(z_addr),
    .ram_sel(z_sel), .ram_wdata(z_wdata), .ram_rdata(z_rdata),
    .ram_ready(z_ready), .ram_err(z_err)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic chk_en   = 1'b0;

  logic [31:0] m_mem [0:DEPTH-1];
  logic [3:0]  m_par [0:DEPTH-1];
  logic [31:0] m_last_rdata = 32'd0;
  logic [31:0] obs_rdata;
  logic        obs_err;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] even_par(input logic [31:0] w);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ($countones(w[8*i +: 8]) % 2) == 1;
    return p;
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    u_dut.ram_mem[idx] = d;
`ifdef DMEM_PARITY_EN
    u_dut.ram_par[idx] = even_par(d);
`endif
    m_mem[idx] = d;
    m_par[idx] = even_par(d);
  endtask

  // Issue one request, queue its expected response, wait for it, then commit a write to the model.
  task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] wdata, input logic junk);
    logic [31:0] idx;
    logic        ok;
    logic [3:0]  newp;
    exp_t        e;
    idx = addr >> 2;
    ok  = idx < DEPTH;
    e.err       = !ok;
    e.chk_rdata = !(we && ok);
    e.rdata     = 32'd0;
    if (ok && !we) begin
      e.rdata = m_mem[idx];
      if (even_par(m_mem[idx]) != m_par[idx]) begin
`ifdef DMEM_PARITY_EN
        e.err = 1'b1;
`endif
      end
    end
    @(negedge clk);
    ram_ce = 1'b1; ram_we = we; ram_addr = addr; ram_sel = sel; ram_wdata = wdata;
    @(posedge clk); #1;
    e.due = cyc + W;
    exp_q.push_back(e);
    if (junk) begin
      ram_we = ~we; ram_addr = ~addr; ram_sel = ~sel; ram_wdata = ~wdata;
      @(posedge clk); #1;
    end
    ram_ce = 1'b0; ram_we = 1'b0; ram_addr = 32'd0; ram_sel = 4'd0; ram_wdata = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check("req_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    if (we && ok) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      newp = even_par(m_mem[idx]);
      for (int b = 0; b < 4; b++)
        if (sel[b]) m_par[idx][b] = newp[b];
    end
  endtask

  // Every cycle: a ready pulse must match the head of the queue; otherwise err is low and rdata holds.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (chk_en) begin
      if (ram_ready) begin
        obs_rdata = ram_rdata;
        obs_err   = ram_err;
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'(ram_ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ready_latency", cyc, e.due);
          check("resp_err", 32'(ram_err), 32'(e.err));
          if (e.chk_rdata) begin
            check("resp_rdata", ram_rdata, e.rdata);
            m_last_rdata = e.rdata;
          end
        end
      end else begin
        check("idle_err", 32'(ram_err), 32'd0);
        check("rdata_hold", ram_rdata, m_last_rdata);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    ram_ce = 0; ram_we = 0; ram_addr = 0; ram_sel = 0; ram_wdata = 0;
    z_ce = 0; z_we = 0; z_addr = 0; z_sel = 0; z_wdata = 0;
    for (int i = 0; i < 16; i++) preload(i, 32'd0);
    preload(0, 32'h0F0000FF);
    preload(2047, 32'h7E570BAD);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset_ready", 32'(ram_ready), 32'd0);
    check("reset_err", 32'(ram_err), 32'd0);
    check("reset_rdata", ram_rdata, 32'd0);
    check("reset_ready_w0", 32'(z_ready), 32'd0);
    chk_en = 1'b1;

    req(1'b0, 32'd0, 4'hF, 32'd0, 1'b0);
    check("read0_data", obs_rdata, 32'h0F0000FF);
    check("read0_err", 32'(obs_err), 32'd0);

    req(1'b1, 32'd12, 4'b0001, 32'h80FFFFFF, 1'b0);
    req(1'b1, 32'd16, 4'b0011, 32'h80FFFFFF, 1'b0);
    req(1'b1, 32'd20, 4'b1111, 32'h80FFFFFF, 1'b0);
    check("sel0001_mem", u_dut.ram_mem[3], 32'h000000FF);
    check("sel0011_mem", u_dut.ram_mem[4], 32'h0000FFFF);
    check("sel1111_mem", u_dut.ram_mem[5], 32'h80FFFFFF);
    check("model_pin3", m_mem[3], 32'h000000FF);
    check("sel0011_model", u_dut.ram_mem[4], m_mem[4]);

    req(1'b1, 32'd20, 4'hF, 32'h12345678, 1'b0);
    req(1'b0, 32'd20, 4'hF, 32'd0, 1'b0);
    check("raw_data", obs_rdata, 32'h12345678);

    req(1'b0, 32'h0000_2000, 4'hF, 32'd0, 1'b0);
    check("oor_read_err", 32'(obs_err), 32'd1);
    check("oor_read_data", obs_rdata, 32'd0);
    req(1'b1, 32'h0000_2000, 4'hF, 32'hFFFFFFFF, 1'b0);
    check("oor_write_err", 32'(obs_err), 32'd1);
    check("oor_write_mem0", u_dut.ram_mem[0], 32'h0F0000FF);

    preload(1, 32'hA5A5A5A5);
    req(1'b1, 32'd4, 4'b0000, 32'h00000000, 1'b0);
    check("sel0_mem", u_dut.ram_mem[1], 32'hA5A5A5A5);

    preload(6, 32'h11223344);
    req(1'b1, 32'd24, 4'b1010, 32'hAABBCCDD, 1'b0);
    check("sel1010_mem", u_dut.ram_mem[6], 32'hAA22CC44);
    req(1'b0, 32'h0000_001B, 4'hF, 32'd0, 1'b1);
    check("lowbits_junk_read", obs_rdata, 32'hAA22CC44);

    req(1'b0, 32'h0000_1FFC, 4'hF, 32'd0, 1'b0);
    check("last_word_data", obs_rdata, 32'h7E570BAD);
    check("last_word_err", 32'(obs_err), 32'd0);

    // Reset during WAIT: no pulse, write dropped, next request accepted normally.
    preload(2, 32'hCAFEF00D);
    @(negedge clk);
    ram_ce = 1'b1; ram_we = 1'b1; ram_addr = 32'd8; ram_sel = 4'hF; ram_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    ram_ce = 1'b0; ram_we = 1'b0; ram_addr = 32'd0; ram_sel = 4'd0; ram_wdata = 32'd0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; m_last_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_mid_mem2", u_dut.ram_mem[2], 32'hCAFEF00D);
    req(1'b0, 32'd8, 4'hF, 32'd0, 1'b0);
    check("rst_mid_read", obs_rdata, 32'hCAFEF00D);

`ifdef DMEM_PARITY_EN
    req(1'b1, 32'd0, 4'hF, 32'h00000001, 1'b0);
    u_dut.ram_mem[0] = u_dut.ram_mem[0] ^ 32'h8;
    m_mem[0] = m_mem[0] ^ 32'h8;
    req(1'b0, 32'd0, 4'hF, 32'd0, 1'b0);
    check("parity_err", 32'(obs_err), 32'd1);
    check("parity_data", obs_rdata, 32'h00000009);
`endif

    // Zero-wait instance: ready directly after the accepting edge.
    u_dut0.ram_mem[1] = 32'h13579BDF;
    u_dut0.ram_mem[2] = 32'h00000000;
`ifdef DMEM_PARITY_EN
    u_dut0.ram_par[1] = even_par(32'h13579BDF);
    u_dut0.ram_par[2] = 4'd0;
`endif
    @(negedge clk);
    z_ce = 1'b1; z_we = 1'b0; z_addr = 32'd4; z_sel = 4'hF;
    @(posedge clk); #1;
    z_ce = 1'b0;
    check("w0_ready", 32'(z_ready), 32'd1);
    check("w0_rdata", z_rdata, 32'h13579BDF);
    check("w0_err", 32'(z_err), 32'd0);
    @(posedge clk); #1;
    check("w0_ready_drop", 32'(z_ready), 32'd0);
    check("w0_rdata_hold", z_rdata, 32'h13579BDF);
    @(negedge clk);
    z_ce = 1'b1; z_we = 1'b1; z_addr = 32'd8; z_sel = 4'b1100; z_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    z_ce = 1'b0; z_we = 1'b0;
    check("w0_wr_ready", 32'(z_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    z_ce = 1'b1; z_addr = 32'd8;
    @(posedge clk); #1;
    z_ce = 1'b0;
    check("w0_rd_ready", 32'(z_ready), 32'd1);
    check("w0_rd_data", z_rdata, 32'h55AA0000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
